gb_sram_rd_mux: RTL and testbench

- Downstream companion of the global-buffer SRAM read-ID generator. Consumes its bank index (rd_id) and produces the read_out_flag and read_SRAM_done signals it needs.
- Issues the actual bank reads and keeps one address counter per bank.
- Steers the returning bank data through a small credit-managed FIFO to a valid/ready output port feeding the PE-side distribution.

---
 rtl/gb_sram_rd_mux.sv | 257 +++++++++++++++++++++++++
 tb/tb_gb_sram_rd_mux.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_sram_rd_mux.sv
// -----------------------------------------------------------------------------
// gb_sram_rd_mux
//
// Purpose:
//   Downstream companion of the global-buffer SRAM read-ID generator. It takes
//   the bank index chosen each cycle (rd_id) and issues the bank read. It keeps
//   one address counter per bank. Returning bank data is steered into a small
//   credit-managed FIFO that feeds a valid/ready output port.
//
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle pulse: load config, clear all state, begin
//   base_addr      in   [ADDR_WIDTH]  start address for every bank (on start)
//   total_words    in   [WCNT_WIDTH]  words in this transfer (on start)
//   rd_id          in   [4]           bank to read this cycle
//   read_out_flag  out  issue strobe; the ID generator advances rd_id on it
//   sram_rd_en     out  [SRAM_NUM_MAX] one-hot bank read enable
//   sram_addr      out  [ADDR_WIDTH]  shared read address, valid with enable
//   sram_rdata     in   [SRAM_NUM_MAX*DATA_WIDTH] packed bank read data
//   out_data       out  [DATA_WIDTH]  FIFO head word
//   out_valid      out  FIFO non-empty
//   out_ready      in   consumer accepts out_data on out_valid & out_ready
//   read_SRAM_done out  level: every word issued and drained
//
// Configuration:
//   SRAM_RD_PIPE2_EN - when defined, the SRAM read latency is two cycles. A
//   second bank-index/valid stage is added, and the credit check counts both
//   stages. When undefined, the read latency is one cycle.
// -----------------------------------------------------------------------------
module gb_sram_rd_mux #(
  parameter int DATA_WIDTH   = 96,
  parameter int SRAM_NUM_MAX = 12,
  parameter int ADDR_WIDTH   = 10,
  parameter int FIFO_DEPTH   = 4,
  parameter int WCNT_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [WCNT_WIDTH-1:0]                total_words,
  input  logic [3:0]                           rd_id,
  output logic                                 read_out_flag,
  output logic [SRAM_NUM_MAX-1:0]              sram_rd_en,
  output logic [ADDR_WIDTH-1:0]                sram_addr,
  input  logic [SRAM_NUM_MAX*DATA_WIDTH-1:0]   sram_rdata,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 read_SRAM_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [WCNT_WIDTH-1:0]   total_r;
  logic [WCNT_WIDTH-1:0]   issued_r;
  logic [ADDR_WIDTH-1:0]   addr_cnt_r [SRAM_NUM_MAX];
  logic                    done_r;

  // Read-return pipeline: bank index captured at issue time
  logic                    p1_vld_r;
  logic [3:0]              p1_id_r;

  // Output FIFO
  logic [DATA_WIDTH-1:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        fifo_cnt_r;

  logic [1:0]              inflight_s;
  logic [1:0]              inflight_nxt_s;
  logic                    ret_vld_s;
  logic [3:0]              ret_id_s;
  logic [SUM_W-1:0]        credit_sum_s;
  logic                    issue_s;
  logic [ADDR_WIDTH-1:0]   cur_cnt_s;
  logic [DATA_WIDTH-1:0]   ret_data_s;
  logic                    fifo_ne_s;
  logic                    pop_s;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic                    drained_s;

`ifdef SRAM_RD_PIPE2_EN
  logic                    p2_vld_r;
  logic [3:0]              p2_id_r;

  assign inflight_s     = {1'b0, p1_vld_r} + {1'b0, p2_vld_r};
  // In DRAIN nothing issues, so only stage 1 can still be in flight next cycle
  assign inflight_nxt_s = {1'b0, issue_s} + {1'b0, p1_vld_r};
  assign ret_vld_s      = p2_vld_r;
  assign ret_id_s       = p2_id_r;
`else
  assign inflight_s     = {1'b0, p1_vld_r};
  assign inflight_nxt_s = {1'b0, issue_s};
  assign ret_vld_s      = p1_vld_r;
  assign ret_id_s       = p1_id_r;
`endif

  // Credit: every word in flight already owns a FIFO slot, so a push can never
  // meet a full FIFO. Only registered state is used, never out_ready.
  assign credit_sum_s  = SUM_W'(fifo_cnt_r) + SUM_W'(inflight_s);
  assign issue_s       = (state_r == RUN) && (credit_sum_s < SUM_W'(FIFO_DEPTH));
  assign read_out_flag = issue_s;

  assign fifo_ne_s      = (fifo_cnt_r != {CNT_W{1'b0}});
  assign pop_s          = fifo_ne_s && out_ready;
  assign cnt_nxt_s      = fifo_cnt_r + CNT_W'(ret_vld_s) - CNT_W'(pop_s);
  assign drained_s      = (inflight_nxt_s == 2'd0) && (cnt_nxt_s == {CNT_W{1'b0}});
  assign out_valid      = fifo_ne_s;
  assign out_data       = fifo_mem_r[rd_ptr_r];
  assign read_SRAM_done = done_r;

  // Bank enable decode and address generation for the current issue.
  // An out-of-range rd_id matches no bank, so no enable bit asserts.
  always_comb begin
    sram_rd_en = {SRAM_NUM_MAX{1'b0}};
    cur_cnt_s  = {ADDR_WIDTH{1'b0}};
    for (int k = 0; k < SRAM_NUM_MAX; k++) begin
      sram_rd_en[k] = issue_s && (rd_id == 4'(k));
      cur_cnt_s     = (rd_id == 4'(k)) ? addr_cnt_r[k] : cur_cnt_s;
    end
    // Address wraps modulo 2^ADDR_WIDTH by truncation
    sram_addr = issue_s ? (base_r + cur_cnt_s) : {ADDR_WIDTH{1'b0}};
  end

  // Select the returning bank slice. An invalid bank index yields all-zero data.
  always_comb begin
    ret_data_s = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < SRAM_NUM_MAX; k++) begin
      ret_data_s = (ret_id_s == 4'(k)) ? sram_rdata[k*DATA_WIDTH +: DATA_WIDTH] : ret_data_s;
    end
  end

  // Transfer control: config capture, per-bank counters, issue count, state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      base_r   <= {ADDR_WIDTH{1'b0}};
      total_r  <= {WCNT_WIDTH{1'b0}};
      issued_r <= {WCNT_WIDTH{1'b0}};
      done_r   <= 1'b0;
      for (int k = 0; k < SRAM_NUM_MAX; k++) begin
        addr_cnt_r[k] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (start) begin
      base_r   <= base_addr;
      total_r  <= total_words;
      issued_r <= {WCNT_WIDTH{1'b0}};
      for (int k = 0; k < SRAM_NUM_MAX; k++) begin
        addr_cnt_r[k] <= {ADDR_WIDTH{1'b0}};
      end
      if (total_words == {WCNT_WIDTH{1'b0}}) begin
        state_r <= FINISH;
        done_r  <= 1'b1;
      end else begin
        state_r <= RUN;
        done_r  <= 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        RUN: begin
          if (issue_s) begin
            issued_r <= issued_r + WCNT_WIDTH'(1);
            for (int k = 0; k < SRAM_NUM_MAX; k++) begin
              if (rd_id == 4'(k)) begin
                addr_cnt_r[k] <= addr_cnt_r[k] + ADDR_WIDTH'(1);
              end
            end
            if ((issued_r + WCNT_WIDTH'(1)) == total_r) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Finish on the edge where the last word leaves the FIFO
          if (drained_s) begin
            state_r <= FINISH;
            done_r  <= 1'b1;
          end
        end
        FINISH: begin
          done_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read-return pipeline. start drops every word in flight, including one
  // issued in the start cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_vld_r <= 1'b0;
      p1_id_r  <= 4'd0;
`ifdef SRAM_RD_PIPE2_EN
      p2_vld_r <= 1'b0;
      p2_id_r  <= 4'd0;
`endif
    end else if (start) begin
      p1_vld_r <= 1'b0;
`ifdef SRAM_RD_PIPE2_EN
      p2_vld_r <= 1'b0;
`endif
    end else begin
      p1_vld_r <= issue_s;
      p1_id_r  <= rd_id;
`ifdef SRAM_RD_PIPE2_EN
      p2_vld_r <= p1_vld_r;
      p2_id_r  <= p1_id_r;
`endif
    end
  end

  // Output FIFO. Push and pop may coincide at any fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {CNT_W{1'b0}};
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_mem_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else if (start) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (ret_vld_s) begin
        fifo_mem_r[wr_ptr_r] <= ret_data_s;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      fifo_cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_gb_sram_rd_mux.sv
// -----------------------------------------------------------------------------
// tb_gb_sram_rd_mux
//
// Self-checking bench for gb_sram_rd_mux. The SRAM banks are modelled with
// the configured read latency. A transaction-level reference model keeps an
// issue-order queue of expected words, a list of pending reads with their
// remaining latency, and the per-bank address counts. Each cycle the model
// predicts the outputs, and they are compared with the DUT through check_val.
// -----------------------------------------------------------------------------
module tb_gb_sram_rd_mux;

  localparam int DW = 96;
  localparam int NB = 12;
  localparam int AW = 10;
  localparam int FD = 4;
  localparam int WW = 16;
`ifdef SRAM_RD_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [DW-1:0] w_t;
  typedef struct {
    logic [DW-1:0] data;
    int            rem;
  } pend_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [AW-1:0]      base_addr;
  logic [WW-1:0]      total_words;
  logic [3:0]         rd_id;
  logic               read_out_flag;
  logic [NB-1:0]      sram_rd_en;
  logic [AW-1:0]      sram_addr;
  logic [NB*DW-1:0]   sram_rdata;
  logic [DW-1:0]      out_data;
  logic               out_valid;
  logic               out_ready;
  logic               read_SRAM_done;

  always #5 clk = ~clk;

  gb_sram_rd_mux #(
    .DATA_WIDTH(DW), .SRAM_NUM_MAX(NB), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .WCNT_WIDTH(WW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .total_words(total_words), .rd_id(rd_id), .read_out_flag(read_out_flag),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .read_SRAM_done(read_SRAM_done)
  );

  // Distinct content per (bank, address) so that mis-steering shows up
  function automatic logic [DW-1:0] word_of(input int k, input logic [AW-1:0] a);
    return {8'(k + 1), 6'd0, a, 8'hC3,
            (64'(k) * 64'h9E3779B97F4A7C15) ^ (64'(a) * 64'h00000100000001B3)};
  endfunction

  // ---------------- SRAM bank model ----------------
  logic [DW-1:0]    bank_q [NB];
  logic [NB*DW-1:0] bank_flat;

  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (!rst_n) bank_q[k] <= '0;
      else if (sram_rd_en[k]) bank_q[k] <= word_of(k, sram_addr);
    end
  end

  always_comb begin
    bank_flat = '0;
    for (int k = 0; k < NB; k++) bank_flat[k*DW +: DW] = bank_q[k];
  end

`ifdef SRAM_RD_PIPE2_EN
  always @(posedge clk) sram_rdata <= bank_flat;
`else
  assign sram_rdata = bank_flat;
`endif

  // ---------------- reference model state ----------------
  int            m_running, m_draining, m_done, m_issued, m_total;
  logic [AW-1:0] m_base;
  int            m_cnt [16];
  pend_t         pend_q [$];
  logic [DW-1:0] fifo_q [$];

  // ---------------- bookkeeping ----------------
  int            n_cmp, n_bad;
  int            id_mode, id_ctr;
  int            flag_cnt, hs_cnt, obs_iss, obs_pop;
  logic [AW-1:0] addr_log [$];

  task automatic check_val(input string tag, input w_t got, input w_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_running = 0; m_draining = 0; m_done = 0; m_issued = 0; m_total = 0; m_base = '0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    pend_q.delete();
    fifo_q.delete();
    obs_iss = 0; obs_pop = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_val("rst_flag",  w_t'(read_out_flag),  w_t'(0));
    check_val("rst_rd_en", w_t'(sram_rd_en),     w_t'(0));
    check_val("rst_addr",  w_t'(sram_addr),      w_t'(0));
    check_val("rst_valid", w_t'(out_valid),      w_t'(0));
    check_val("rst_data",  w_t'(out_data),       w_t'(0));
    check_val("rst_done",  w_t'(read_SRAM_done), w_t'(0));
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive inputs, compare with the model, then advance the model
  // across the coming clock edge. rmode: 0 ready low, 1 ready high, 2 random.
  task automatic step(input bit st, input logic [AW-1:0] ba, input int tw, input int rmode);
    bit            exp_flag, pop, was_drain, rdy;
    int            id;
    logic [NB-1:0] exp_en;
    logic [AW-1:0] exp_addr;
    pend_t         e;
    @(negedge clk);
    case (id_mode)
      0:       id = id_ctr % 4;
      1:       id = 2;
      default: id = int'($urandom_range(0, 15));
    endcase
    rdy         = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
    rd_id       = 4'(id);
    start       = st;
    base_addr   = ba;
    total_words = WW'(tw);
    out_ready   = rdy;
    #1;
    exp_flag = (m_running != 0) && ((fifo_q.size() + pend_q.size()) < FD);
    exp_en   = '0;
    exp_addr = m_base + AW'(m_cnt[id]);
    if (exp_flag && id < NB) exp_en[id] = 1'b1;
    check_val("read_out_flag", w_t'(read_out_flag), w_t'(exp_flag));
    check_val("sram_rd_en", w_t'(sram_rd_en), w_t'(exp_en));
    if (exp_en != '0) check_val("sram_addr", w_t'(sram_addr), w_t'(exp_addr));
    check_val("out_valid", w_t'(out_valid), w_t'(fifo_q.size() > 0));
    if (fifo_q.size() > 0) check_val("out_data", out_data, fifo_q[0]);
    check_val("read_SRAM_done", w_t'(read_SRAM_done), w_t'(m_done != 0));

    if (read_out_flag) flag_cnt++;
    if (sram_rd_en != '0) addr_log.push_back(sram_addr);
    if (out_valid && out_ready) hs_cnt++;
    if (!st) begin
      if (read_out_flag) obs_iss++;
      if (out_valid && out_ready) obs_pop++;
      // Words issued but not yet consumed must fit in the FIFO
      check_val("no_overflow", w_t'((obs_iss - obs_pop) <= FD), w_t'(1));
    end
    if (exp_flag) id_ctr++;

    pop = (fifo_q.size() > 0) && rdy;
    if (st) begin
      fifo_q.delete();
      pend_q.delete();
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      m_issued = 0; m_total = tw; m_base = ba;
      m_running = (tw != 0); m_draining = 0; m_done = (tw == 0);
      obs_iss = 0; obs_pop = 0;
    end else begin
      was_drain = (m_draining != 0);
      if (pop) void'(fifo_q.pop_front());
      if (pend_q.size() > 0 && pend_q[0].rem == 1) begin
        fifo_q.push_back(pend_q[0].data);
        void'(pend_q.pop_front());
      end
      foreach (pend_q[i]) pend_q[i].rem--;
      if (exp_flag) begin
        e.data = (id < NB) ? word_of(id, exp_addr) : '0;
        e.rem  = LAT;
        pend_q.push_back(e);
        m_cnt[id]++;
        m_issued++;
        if (m_issued == m_total) begin
          m_running = 0;
          m_draining = 1;
        end
      end
      if (was_drain && pend_q.size() == 0 && fifo_q.size() == 0) begin
        m_draining = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic run_until_done(input int max_cyc, input int rmode);
    int n;
    n = 0;
    while (m_done == 0 && n < max_cyc) begin
      step(1'b0, '0, 0, rmode);
      n++;
    end
    step(1'b0, '0, 0, rmode);
    check_val("done_level", w_t'(read_SRAM_done), w_t'(1));
  endtask

  logic [AW-1:0] wrap_exp [4];

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; total_words = '0; rd_id = '0; out_ready = 1'b0;
    n_cmp = 0; n_bad = 0; id_mode = 0; id_ctr = 0; flag_cnt = 0; hs_cnt = 0;
    wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;
    do_reset();
    repeat (3) step(1'b0, '0, 0, 1);

    // Basic stream: banks 0..3 cycling, 8 words from 0x010
    id_mode = 0; id_ctr = 0; addr_log.delete(); hs_cnt = 0;
    step(1'b1, 10'h010, 8, 1);
    run_until_done(60, 1);
    check_val("basic_words", w_t'(hs_cnt), w_t'(8));
    check_val("basic_nreads", w_t'(addr_log.size()), w_t'(8));
    for (int i = 0; i < 8 && i < addr_log.size(); i++)
      check_val("basic_addr", w_t'(addr_log[i]), w_t'((i < 4) ? 10'h010 : 10'h011));

    // Backpressure: only FIFO_DEPTH issues while the consumer stalls
    flag_cnt = 0; hs_cnt = 0;
    step(1'b1, 10'h020, 12, 0);
    repeat (10) step(1'b0, '0, 0, 0);
    check_val("bp_issues", w_t'(flag_cnt), w_t'(FD));
    run_until_done(200, 1);
    check_val("bp_words", w_t'(hs_cnt), w_t'(12));

    // Zero length transfer
    addr_log.delete();
    step(1'b1, 10'h000, 0, 1);
    repeat (4) step(1'b0, '0, 0, 1);
    check_val("zero_reads", w_t'(addr_log.size()), w_t'(0));

    // Restart mid-transfer with reads in flight and words queued
    id_ctr = 0;
    step(1'b1, 10'h040, 10, 0);
    repeat (3) step(1'b0, '0, 0, 0);
    step(1'b1, 10'h100, 6, 1);
    addr_log.delete(); hs_cnt = 0;
    run_until_done(100, 1);
    check_val("restart_words", w_t'(hs_cnt), w_t'(6));
    check_val("restart_nreads", w_t'(addr_log.size()), w_t'(6));
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check_val("restart_addr", w_t'(addr_log[i]), w_t'(10'h100));

    // Address wrap on bank 2
    id_mode = 1; addr_log.delete();
    step(1'b1, 10'h3FE, 4, 1);
    run_until_done(50, 1);
    check_val("wrap_nreads", w_t'(addr_log.size()), w_t'(4));
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check_val("wrap_addr", w_t'(addr_log[i]), w_t'(wrap_exp[i]));

    // Random banks (including invalid ids), random backpressure, 64-word run
    id_mode = 2;
    for (int t = 0; t < 3; t++) begin
      hs_cnt = 0;
      step(1'b1, AW'($urandom), (t == 2) ? 64 : int'($urandom_range(1, 30)), 2);
      run_until_done(2000, 2);
    end
    check_val("rand_words", w_t'(hs_cnt), w_t'(64));

    // Reset in the middle of a transfer, then a clean short transfer
    id_mode = 0;
    step(1'b1, 10'h055, 20, 1);
    repeat (5) step(1'b0, '0, 0, 1);
    do_reset();
    repeat (3) step(1'b0, '0, 0, 1);
    hs_cnt = 0;
    step(1'b1, 10'h007, 3, 1);
    run_until_done(50, 1);
    check_val("post_rst_words", w_t'(hs_cnt), w_t'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
